ps2_ascii_decoder: RTL and testbench

- Upstream keyboard front end for the character display buffer.
- Receives PS/2 frames, tracks Shift, Caps Lock and the extended/break prefixes, and translates make codes into the ASCII/control codes the buffer consumes.
- Control codes: printable characters, arrows 0x11/0x14/0x12/0x13, Enter 0x0D, Backspace 0x7F, Clear 0x02.
- Presents each code on `ascii` with a `dataReady` pulse. The consumer clocks on the rising edge of `dataReady`, so `ascii` must be stable around that edge.

---
 rtl/disp_kbd_pkg.sv | 35 +++
 rtl/ps2_rx.sv | 129 ++++++++++++
 rtl/ps2_ascii_decoder.sv | 147 ++++++++++++++
 tb/tb_ps2_ascii_decoder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/disp_kbd_pkg.sv
// Shared constants for the PS/2 keyboard front end: set-2 scan codes, the
// control codes the display buffer understands, and the receiver state type.
package disp_kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BS     = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    localparam logic [7:0] ASC_LEFT   = 8'h11;
    localparam logic [7:0] ASC_RIGHT  = 8'h14;
    localparam logic [7:0] ASC_UP     = 8'h12;
    localparam logic [7:0] ASC_DOWN   = 8'h13;
    localparam logic [7:0] ASC_ENTER  = 8'h0D;
    localparam logic [7:0] ASC_BS     = 8'h7F;
    localparam logic [7:0] ASC_CLR    = 8'h02;
    localparam logic [7:0] ASC_CURSOR = 8'h7F;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronisers, clock-line glitch filter, frame FSM and
// mid-frame timeout. Define PS2_PARITY_CHECK_EN to reject bytes with bad odd parity.
module ps2_rx
    import disp_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk_pix,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_vld,
    output logic       o_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic          r_clk_filt;
    logic [FW-1:0] r_filt_cnt;
    rx_state_t     r_state;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [TW-1:0] r_to_cnt;
`ifdef PS2_PARITY_CHECK_EN
    logic          r_parity;
`endif

    logic w_accept;
    logic w_fall;
    logic w_dat;
    logic w_timeout;
    logic w_par_ok;

    assign w_dat     = r_dat_sync[1];
    assign w_accept  = (r_clk_sync[1] != r_clk_filt) && (r_filt_cnt == FW'(FILTER_LEN - 1));
    assign w_fall    = w_accept && r_clk_filt;
    assign w_timeout = (r_state != RX_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
    assign w_par_ok = ^{r_shift, r_parity};
`else
    assign w_par_ok = 1'b1;
`endif

    // Lines idle high, so the synchronisers and filter come out of reset high.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            if (r_clk_sync[1] == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (w_accept) begin
                r_clk_filt <= r_clk_sync[1];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RX_IDLE;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_to_cnt   <= '0;
            o_byte     <= '0;
            o_byte_vld <= 1'b0;
            o_err      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            o_byte_vld <= 1'b0;
            o_err      <= 1'b0;
            if (w_fall || r_state == RX_IDLE)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 1'b1;

            if (w_timeout) begin
                r_state <= RX_IDLE;
                o_err   <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    RX_IDLE: begin
                        if (!w_dat) begin
                            r_state   <= RX_DATA;
                            r_bit_idx <= '0;
                        end
                    end
                    RX_DATA: begin
                        r_shift   <= {w_dat, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7)
                            r_state <= RX_PARITY;
                    end
                    RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        r_parity <= w_dat;
`endif
                        r_state <= RX_STOP;
                    end
                    RX_STOP: begin
                        r_state <= RX_IDLE;
                        if (w_dat && w_par_ok) begin
                            o_byte     <= r_shift;
                            o_byte_vld <= 1'b1;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 keyboard to ASCII/control-code front end for the character display buffer.
// Build option: PS2_PARITY_CHECK_EN enables odd-parity checking in the receiver.
module ps2_ascii_decoder
    import disp_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int PULSE_LEN      = 4
) (
    input  logic       clk_pix,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii,
    output logic       dataReady,
    output logic       caps_led,
    output logic       frame_err
);

    localparam int CW = $clog2(2 * PULSE_LEN + 1);

    logic [7:0]    w_byte;
    logic          w_byte_vld;
    logic [7:0]    w_code;
    logic          w_prefix;
    logic          w_is_shift;
    logic          w_emit;
    logic          w_free;

    logic          r_ext;
    logic          r_brk;
    logic          r_shift;
    logic          r_caps;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_pend;
    logic          r_pend_vld;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk_pix    (clk_pix),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .o_byte     (w_byte),
        .o_byte_vld (w_byte_vld),
        .o_err      (frame_err)
    );

    assign caps_led   = r_caps;
    assign w_prefix   = (w_byte == SC_EXT) || (w_byte == SC_BRK);
    assign w_is_shift = (w_byte == SC_LSHIFT) || (w_byte == SC_RSHIFT);
    assign w_emit     = w_byte_vld && !w_prefix && !r_brk && (w_code != 8'h00);
    assign w_free     = (r_cnt == '0);

    // A zero code means "unmapped"; letters are produced lowercase and folded afterwards.
    always_comb begin
        w_code = 8'h00;
        if (r_ext) begin
            case (w_byte)
                SC_UP:    w_code = ASC_UP;
                SC_DOWN:  w_code = ASC_DOWN;
                SC_LEFT:  w_code = ASC_LEFT;
                SC_RIGHT: w_code = ASC_RIGHT;
                default:  w_code = 8'h00;
            endcase
        end else begin
            case (w_byte)
                8'h1C: w_code = "a";  8'h32: w_code = "b";  8'h21: w_code = "c";
                8'h23: w_code = "d";  8'h24: w_code = "e";  8'h2B: w_code = "f";
                8'h34: w_code = "g";  8'h33: w_code = "h";  8'h43: w_code = "i";
                8'h3B: w_code = "j";  8'h42: w_code = "k";  8'h4B: w_code = "l";
                8'h3A: w_code = "m";  8'h31: w_code = "n";  8'h44: w_code = "o";
                8'h4D: w_code = "p";  8'h15: w_code = "q";  8'h2D: w_code = "r";
                8'h1B: w_code = "s";  8'h2C: w_code = "t";  8'h3C: w_code = "u";
                8'h2A: w_code = "v";  8'h1D: w_code = "w";  8'h22: w_code = "x";
                8'h35: w_code = "y";  8'h1A: w_code = "z";
                8'h45: w_code = "0";  8'h16: w_code = "1";  8'h1E: w_code = "2";
                8'h26: w_code = "3";  8'h25: w_code = "4";  8'h2E: w_code = "5";
                8'h36: w_code = "6";  8'h3D: w_code = "7";  8'h3E: w_code = "8";
                8'h46: w_code = "9";
                SC_SPACE: w_code = 8'h20;
                SC_ENTER: w_code = ASC_ENTER;
                SC_BS:    w_code = ASC_BS;
                SC_ESC:   w_code = ASC_CLR;
                default:  w_code = 8'h00;
            endcase
            if (w_code >= "a" && w_code <= "z" && (r_shift ^ r_caps))
                w_code = w_code - 8'h20;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
            r_shift <= 1'b0;
            r_caps  <= 1'b0;
        end else if (w_byte_vld) begin
            if (w_byte == SC_EXT) begin
                r_ext <= 1'b1;
            end else if (w_byte == SC_BRK) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
                if (r_brk) begin
                    if (w_is_shift)
                        r_shift <= 1'b0;
                end else begin
                    if (w_is_shift)
                        r_shift <= 1'b1;
                    if (w_byte == SC_CAPS)
                        r_caps <= ~r_caps;
                end
            end
        end
    end

    // r_cnt spans the pulse plus its gap; ascii only reloads once it has run down.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            ascii      <= 8'h00;
            dataReady  <= 1'b0;
            r_cnt      <= '0;
            r_pend     <= 8'h00;
            r_pend_vld <= 1'b0;
        end else begin
            dataReady <= (r_cnt > CW'(PULSE_LEN));
            if (w_free && (r_pend_vld || w_emit)) begin
                ascii      <= r_pend_vld ? r_pend : w_code;
                r_cnt      <= CW'(2 * PULSE_LEN);
                r_pend     <= w_code;
                r_pend_vld <= r_pend_vld && w_emit;
            end else begin
                if (!w_free)
                    r_cnt <= r_cnt - 1'b1;
                if (w_emit && !r_pend_vld) begin
                    r_pend     <= w_code;
                    r_pend_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder: bit-bangs PS/2 frames and checks emitted codes.
module tb_ps2_ascii_decoder;

    logic       clk_pix  = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] ascii;
    logic       dataReady;
    logic       caps_led;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] q_codes[$];
    logic       prev_rdy     = 1'b0;
    logic [7:0] prev_ascii   = 8'h00;
    int         since_chg    = 0;
    int         hi_cnt       = 0;
    int         last_lead    = -1;
    int         last_width   = -1;
    int         err_cnt      = 0;
    int         chg_while_hi = 0;
    int         e0;
    wire        w_chg = (ascii !== prev_ascii);

    ps2_ascii_decoder dut (
        .clk_pix   (clk_pix),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ascii     (ascii),
        .dataReady (dataReady),
        .caps_led  (caps_led),
        .frame_err (frame_err)
    );

    always #5 clk_pix = ~clk_pix;

    // Observer: logs each dataReady pulse, its lead after an ascii change and its width.
    always @(negedge clk_pix) begin
        since_chg <= w_chg ? 0 : since_chg + 1;
        if (w_chg && dataReady && prev_rdy)
            chg_while_hi <= chg_while_hi + 1;
        if (dataReady && !prev_rdy) begin
            q_codes.push_back(ascii);
            last_lead <= w_chg ? 0 : since_chg + 1;
            hi_cnt    <= 1;
        end else if (dataReady) begin
            hi_cnt <= hi_cnt + 1;
        end
        if (!dataReady && prev_rdy)
            last_width <= hi_cnt;
        if (frame_err)
            err_cnt <= err_cnt + 1;
        prev_rdy   <= dataReady;
        prev_ascii <= ascii;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // exp holds up to three codes, first code in the low byte.
    task automatic expect_codes(input string tag, input int n, input logic [23:0] exp);
        @(negedge clk_pix);
        chk({tag, "_count"}, q_codes.size(), n);
        for (int i = 0; i < n && i < q_codes.size(); i++)
            chk(tag, int'(q_codes[i]), int'(exp[8*i +: 8]));
        $display("step %s: %0d code(s) observed", tag, q_codes.size());
        q_codes.delete();
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (10) @(posedge clk_pix);
        ps2_clk = 1'b0;
        repeat (20) @(posedge clk_pix);
        ps2_clk = 1'b1;
        repeat (10) @(posedge clk_pix);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic flip = 1'b0);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < 11; i++)
            ps2_bit(f[i]);
        ps2_data = 1'b1;
        repeat (40) @(posedge clk_pix);
    endtask

    initial begin
        repeat (3) @(negedge clk_pix);
        chk("rst_ascii", ascii, 8'h00);
        chk("rst_ready", dataReady, 0);
        chk("rst_caps", caps_led, 0);
        chk("rst_err", frame_err, 0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk_pix);

        send_byte(8'h1C);
        expect_codes("a", 1, 24'h000061);
        chk("pulse_width", last_width, 4);
        chk("pulse_lead", last_lead, 1);

        send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h12); send_byte(8'h1C);
        expect_codes("shift_seq", 2, 24'h006141);

        send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0); send_byte(8'h6B);
        send_byte(8'h5A);
        expect_codes("up_left_enter", 3, 24'h0D1112);
        send_byte(8'hE0); send_byte(8'h72); send_byte(8'hE0); send_byte(8'h74);
        expect_codes("down_right", 2, 24'h001413);
        send_byte(8'hE0); send_byte(8'h1C);
        expect_codes("ext_unmapped", 0, 24'h0);

        send_byte(8'h12); send_byte(8'h16); send_byte(8'hF0); send_byte(8'h12);
        send_byte(8'h29); send_byte(8'h76);
        expect_codes("digit_space_esc", 3, 24'h022031);

        send_byte(8'h58);
        expect_codes("caps_press", 0, 24'h0);
        chk("caps_on", caps_led, 1);
        send_byte(8'h1C);
        expect_codes("caps_a", 1, 24'h000041);
        send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12);
        expect_codes("caps_shift_a", 1, 24'h000061);
        send_byte(8'h58);
        @(negedge clk_pix);
        chk("caps_off", caps_led, 0);

        e0 = err_cnt;
        send_byte(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        expect_codes("bad_parity", 0, 24'h0);
        chk("parity_err", err_cnt - e0, 1);
`else
        expect_codes("bad_parity", 1, 24'h000061);
        chk("parity_err", err_cnt - e0, 0);
`endif

        e0 = err_cnt;
        ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0);
        ps2_data = 1'b1;
        repeat (25100) @(posedge clk_pix);
        @(negedge clk_pix);
        chk("timeout_err", err_cnt - e0, 1);
        expect_codes("timeout", 0, 24'h0);
        send_byte(8'h66);
        expect_codes("backspace", 1, 24'h00007F);

        send_byte(8'h58);
        @(negedge clk_pix);
        chk("caps_again", caps_led, 1);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        @(negedge clk_pix);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_pix);
        chk("midrst_ascii", ascii, 8'h00);
        chk("midrst_ready", dataReady, 0);
        chk("midrst_caps", caps_led, 0);
        chk("midrst_err", frame_err, 0);
        rst_n = 1'b1;
        q_codes.delete();
        e0 = err_cnt;
        repeat (26000) @(posedge clk_pix);
        expect_codes("after_rst", 0, 24'h0);
        chk("after_rst_err", err_cnt - e0, 0);
        send_byte(8'h1C);
        expect_codes("post_rst_a", 1, 24'h000061);

        chk("ascii_stable_while_high", chg_while_hi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
